pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer that generates the `pc` consumed by the instruction fetch stage. Each clock it selects the next instruction address (increment, jump, call, return or hold), maintains a small return-address stack, and runs a RUN/HALT/STEP state machine driven by the decoder's halt request and the debounced resume/step buttons. It sits directly upstream of `instr_fetch` and downstream of the decoder and the debouncer.

## Interface
- `RESET_PC`, 12'h000, address loaded into `pc[11:0]` on reset.
- `STACK_DEPTH`, 4, number of return-address entries (2..8).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `jmp_en`  in  1  unconditional jump to `jump_addr`.
- `call_en`  in  1  push return address, then jump to `jump_addr`.
- `ret_en`  in  1  pop the return address into `pc`.
- `jump_addr`  in  12  jump/call target from the fetch stage.
- `halt_req`  in  1  decoded HALT instruction.
- `resume`  in  1  one-cycle debounced pulse; leave HALT.
- `step`  in  1  one-cycle debounced pulse; execute one instruction from HALT.
- `pc`  out  16  program counter; `pc[15:12]` always 0.
- `halted`  out  1  high while in HALT.
- `stack_cnt`  out  $clog2(STACK_DEPTH+1)  valid stack entries.
- `stack_err`  out  1  sticky overflow/underflow flag.

## Operation
- Reset (async, `rst_n`=0): `pc`={4'h0,RESET_PC}, state RUN, `halted`=0, `stack_cnt`=0, `stack_err`=0, stack contents don't-care. Reset mid-HALT or mid-STEP returns to RUN; stack is emptied.
- All address arithmetic is 12-bit; pc+1 wraps 12'hFFF -> 12'h000. `pc[15:12]` never leaves 0.
- Normal update (RUN, and the single STEP cycle), priority high to low:
  - `halt_req`: `pc` held, next state HALT.
  - `ret_en`: if `stack_cnt`>0, `pc`<=top entry, `stack_cnt`-1. If empty, `stack_err`<=1 and `pc`<=pc+1.
  - `call_en`: `pc`<=`jump_addr`. If `stack_cnt`<STACK_DEPTH, push pc+1 and increment `stack_cnt`. If full, drop the push and set `stack_err`<=1. The jump is still taken.
  - `jmp_en`: `pc`<=`jump_addr`.
  - Otherwise: `pc`<=pc+1.
- Lower-priority controls asserted alongside a higher one are ignored with no side effects (for example, `call_en` with `ret_en` causes no push).
- State machine:
  - RUN: normal update. `halt_req` -> HALT.
  - HALT: `pc` and stack frozen; `jmp_en`, `call_en`, `ret_en` and `halt_req` ignored.
    - `resume` -> RUN with `pc`<=pc+1.
    - Else `step` -> STEP with `pc`<=pc+1.
    - `resume` has priority over `step` if both arrive in the same cycle.
  - STEP: exactly one normal update, then HALT. If that instruction is itself `halt_req`, `pc` is held and the next state is HALT.
  - `resume`/`step` are ignored in RUN and STEP.
- `halted` = (state==HALT), registered.
- `stack_err` clears only on reset.

## Timing
- Controls are sampled on the rising edge; `pc` reflects the decision in the same edge (one-cycle latency, no bubbles). Jump/call/return cost no extra cycles here.
- `halted` rises on the edge that accepts `halt_req` and falls on the edge that accepts `resume`.
- `step` produces exactly two `pc` changes at most: the HALT->STEP edge and the STEP->HALT edge.
- `stack_cnt` and `stack_err` update on the same edge as the corresponding `pc` change.
- No combinational path from inputs to outputs.

## Test plan
- Reset then 5 idle cycles -> `pc` 0x000,0x001,...,0x005; `halted`=0, `stack_cnt`=0. Assert `rst_n`=0 mid-cycle -> `pc`=0x000 immediately.
- At `pc`=0x010, pulse `call_en` with `jump_addr`=0x200 -> `pc`=0x200, `stack_cnt`=1. Two cycles later pulse `ret_en` -> `pc`=0x011, `stack_cnt`=0. At `pc`=0xFFF with no controls -> next `pc`=0x000.
- With STACK_DEPTH=4, issue 5 calls -> fifth call jumps, `stack_cnt` stays 4, `stack_err`=1. Pop 5 times -> 4 valid returns, fifth gives pc+1; `stack_err` still 1.
- `halt_req` at `pc`=0x020 -> `halted`=1, `pc` stays 0x020 for 10 cycles despite `jmp_en`. Pulse `step` -> `pc`=0x021 then 0x022, `halted`=1 again. Pulse `resume` -> `pc`=0x023, `halted`=0.
- `resume` and `step` pulsed in the same cycle while halted -> RUN, `pc`+1 once. `call_en` with `ret_en` at `stack_cnt`=1 -> pop only.
- `halt_req` together with `jmp_en` -> halt wins, `pc` held; reset asserted while halted -> RUN, `pc`=RESET_PC, `stack_cnt`=0, `stack_err`=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with a return-address stack and a RUN/HALT/STEP control FSM.
module pc_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter int STACK_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jmp_en,
  input  logic call_en,
  input  logic ret_en,
  input  logic [11:0] jump_addr,
  input  logic halt_req,
  input  logic resume,
  input  logic step,
  output logic [15:0] pc,
  output logic halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_cnt,
  output logic stack_err
);
  localparam int CW = $clog2(STACK_DEPTH+1);
  localparam logic [1:0] RUN = 2'd0, HALT = 2'd1, STEP = 2'd2;
  logic [1:0] state, state_nxt;
  logic [11:0] pc_r, pc_nxt, pc_inc;
  logic [11:0] stk [2**CW];
  logic [CW-1:0] cnt, top;
  logic err, run, empty, full, do_halt, do_ret, do_call, do_jmp;
  always_comb begin
    pc_inc = pc_r + 12'd1;
    run = state != HALT;
    top = cnt - 1'b1;
    empty = cnt == '0;
    full = cnt == CW'(STACK_DEPTH);
    do_halt = run && halt_req;
    do_ret = run && !halt_req && ret_en;
    do_call = run && !halt_req && !ret_en && call_en;
    do_jmp = run && !halt_req && !ret_en && !call_en && jmp_en;
    pc_nxt = !run ? ((resume || step) ? pc_inc : pc_r)
           : do_halt ? pc_r
           : (do_ret && !empty) ? stk[top]
           : (do_call || do_jmp) ? jump_addr
           : pc_inc;
    state_nxt = state == HALT ? (resume ? RUN : step ? STEP : HALT)
              : state == STEP ? HALT
              : halt_req ? HALT : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      halted <= 1'b0;
      pc_r <= RESET_PC;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      halted <= state_nxt == HALT;
      pc_r <= pc_nxt;
      if (do_ret && !empty) cnt <= top;
      else if (do_call && !full) cnt <= cnt + 1'b1;
      if ((do_ret && empty) || (do_call && full)) err <= 1'b1;
    end
  end
  // Stack contents need no reset; only entries below cnt are ever read.
  always_ff @(posedge clk) if (do_call && !full) stk[cnt] <= pc_inc;
  assign pc = {4'h0, pc_r};
  assign stack_cnt = cnt;
  assign stack_err = err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan plus random traffic against a queue-based reference model.
module tb_pc_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic jmp_en = 1'b0, call_en = 1'b0, ret_en = 1'b0, halt_req = 1'b0, resume = 1'b0, step = 1'b0;
  logic [11:0] jump_addr = '0;
  logic [15:0] pc;
  logic halted;
  logic [2:0] stack_cnt;
  logic stack_err;
  int checks = 0, failures = 0;
  int mpc = 0;
  bit mhalt = 0, mstep = 0, merr = 0;
  int q[$];

  pc_sequencer #(.RESET_PC(12'h000), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .jmp_en(jmp_en), .call_en(call_en), .ret_en(ret_en),
    .jump_addr(jump_addr), .halt_req(halt_req), .resume(resume), .step(step),
    .pc(pc), .halted(halted), .stack_cnt(stack_cnt), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(bit j, bit c, bit r, int a, bit h, bit res, bit st);
    bit was_step;
    if (mhalt) begin
      if (res || st) begin
        mhalt = 0;
        mstep = !res;
        mpc = (mpc + 1) % 4096;
      end
    end else begin
      was_step = mstep;
      mstep = 0;
      if (h) mhalt = 1;
      else begin
        if (r) begin
          if (q.size() > 0) mpc = q.pop_back();
          else begin merr = 1; mpc = (mpc + 1) % 4096; end
        end else if (c) begin
          if (q.size() < 4) q.push_back((mpc + 1) % 4096);
          else merr = 1;
          mpc = a;
        end else if (j) mpc = a;
        else mpc = (mpc + 1) % 4096;
        if (was_step) mhalt = 1;
      end
    end
  endtask

  task automatic cyc(bit j, bit c, bit r, logic [11:0] a, bit h, bit res, bit st);
    jmp_en = j; call_en = c; ret_en = r; jump_addr = a; halt_req = h; resume = res; step = st;
    @(posedge clk);
    model_step(j, c, r, int'(a), h, res, st);
    #1;
    chk("pc", pc, 32'(mpc));
    chk("halted", halted, 32'(mhalt));
    chk("stack_cnt", stack_cnt, q.size());
    chk("stack_err", stack_err, 32'(merr));
    {jmp_en, call_en, ret_en, halt_req, resume, step} = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 12'h0, 0, 0, 0);
  endtask

  task automatic pin(string n, logic [15:0] e);
    chk({n, "_dut"}, pc, e);
    chk({n, "_model"}, mpc, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mpc = 0; mhalt = 0; mstep = 0; merr = 0; q.delete();
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", halted, 32'h0);
    chk("rst_cnt", stack_cnt, 32'h0);
    chk("rst_err", stack_err, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    idle(5);
    pin("idle5", 16'h005);
    do_reset();
    idle(16);
    pin("at10", 16'h010);
    cyc(0, 1, 0, 12'h200, 0, 0, 0);
    pin("call200", 16'h200);
    chk("call_cnt", stack_cnt, 32'd1);
    idle(2);
    cyc(0, 0, 1, 12'h0, 0, 0, 0);
    pin("ret011", 16'h011);
    cyc(1, 0, 0, 12'hFFF, 0, 0, 0);
    idle(1);
    pin("wrap", 16'h000);
    cyc(1, 0, 0, 12'h050, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 12'h100, 0, 0, 0);
    chk("ovf_cnt", stack_cnt, 32'd4);
    chk("ovf_err", stack_err, 32'd1);
    pin("ovf_pc", 16'h100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 12'h0, 0, 0, 0);
    pin("pop4", 16'h051);
    cyc(0, 0, 1, 12'h0, 0, 0, 0);
    pin("udf", 16'h052);
    chk("udf_err", stack_err, 32'd1);
    do_reset();
    cyc(1, 0, 0, 12'h020, 0, 0, 0);
    cyc(0, 0, 0, 12'h0, 1, 0, 0);
    pin("halt", 16'h020);
    chk("halt_flag", halted, 32'd1);
    for (int i = 0; i < 10; i++) cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), 12'($urandom), 1, 0, 0);
    pin("frozen", 16'h020);
    cyc(0, 0, 0, 12'h0, 0, 0, 1);
    pin("step1", 16'h021);
    idle(1);
    pin("step2", 16'h022);
    chk("step_halt", halted, 32'd1);
    cyc(0, 0, 0, 12'h0, 0, 1, 0);
    pin("resume", 16'h023);
    chk("resume_flag", halted, 32'd0);
    cyc(0, 0, 0, 12'h0, 1, 0, 0);
    cyc(0, 0, 0, 12'h0, 0, 1, 1);
    idle(1);
    pin("res_step", 16'h025);
    chk("res_step_flag", halted, 32'd0);
    cyc(0, 1, 0, 12'h300, 0, 0, 0);
    cyc(1, 1, 1, 12'h400, 0, 0, 0);
    pin("call_ret", 16'h026);
    chk("call_ret_cnt", stack_cnt, 32'd0);
    cyc(1, 0, 0, 12'h700, 1, 0, 0);
    pin("halt_jmp", 16'h026);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i % 400 == 399) do_reset();
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
          12'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
